// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-return bus between the execution units, the
// common data bus arbiter, and the RS/ROB snoopers.
// The master side is the producer/consumer environment and the slave side is the arbiter.
`timescale 1ns/1ps
interface cdb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int RD_W   = 4
);
  logic              flush;
  logic              add_valid;
  logic              add_ready;
  logic [TAG_W-1:0]  add_rob_ind;
  logic [RD_W-1:0]   add_rd;
  logic [DATA_W-1:0] add_data;
  logic              mul_valid;
  logic              mul_ready;
  logic [TAG_W-1:0]  mul_rob_ind;
  logic [RD_W-1:0]   mul_rd;
  logic [DATA_W-1:0] mul_data;
  logic              cdb_valid;
  logic              cdb_src;
  logic [TAG_W-1:0]  cdb_rob_ind;
  logic [RD_W-1:0]   cdb_rd;
  logic [DATA_W-1:0] cdb_data;

  modport master (
    output flush,
    output add_valid, add_rob_ind, add_rd, add_data,
    output mul_valid, mul_rob_ind, mul_rd, mul_data,
    input  add_ready, mul_ready,
    input  cdb_valid, cdb_src, cdb_rob_ind, cdb_rd, cdb_data
  );

  modport slave (
    input  flush,
    input  add_valid, add_rob_ind, add_rd, add_data,
    input  mul_valid, mul_rob_ind, mul_rd, mul_data,
    output add_ready, mul_ready,
    output cdb_valid, cdb_src, cdb_rob_ind, cdb_rd, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers add/mul execution results in per-source FIFOs,
// round-robin arbitrates between the FIFO heads, and broadcasts one result
// per cycle on the common data bus. Source index 0 = add, 1 = mul.
// Optional macro CDB_PERF_EN adds saturating broadcast/conflict counters.
`timescale 1ns/1ps
module cdb_arbiter #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int RD_W   = 4,
  parameter int DEPTH  = 2
) (
  input  logic         clk1,
  input  logic         reset,
  cdb_arbiter_if.slave bus
`ifdef CDB_PERF_EN
  ,
  output logic [15:0]  perf_add_cnt,
  output logic [15:0]  perf_mul_cnt,
  output logic [15:0]  perf_conflict_cnt
`endif
);

  localparam int ENT_W = TAG_W + RD_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ENT_W-1:0] mem [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [CNT_W-1:0] cnt [2];
  logic [ENT_W-1:0] in_ent [2];
  logic [1:0]       in_vld;
  logic [1:0]       ne;
  logic [1:0]       rdy;
  logic [1:0]       push;
  logic [1:0]       gnt;
  logic [1:0]       pop;
  logic             rr_ptr;
  logic             any_gnt;
  logic [ENT_W-1:0] head_p0;
  logic             vld_p1;
  logic             src_p1;
  logic [ENT_W-1:0] ent_p1;

  assign in_vld[0] = bus.add_valid;
  assign in_vld[1] = bus.mul_valid;
  assign in_ent[0] = {bus.add_rob_ind, bus.add_rd, bus.add_data};
  assign in_ent[1] = {bus.mul_rob_ind, bus.mul_rd, bus.mul_data};

  // FIFO status from registered counts; flush blocks every push
  always_comb begin
    ne   = '0;
    rdy  = '0;
    push = '0;
    for (int s = 0; s < 2; s++) begin
      ne[s]   = (cnt[s] != '0);
      rdy[s]  = (cnt[s] != FULL_CNT);
      push[s] = in_vld[s] && rdy[s] && !bus.flush;
    end
  end

  // ---- stage p0: round-robin grant over the FIFO heads
  assign gnt[0]  = ne[0] && (!ne[1] || !rr_ptr);
  assign gnt[1]  = ne[1] && (!ne[0] ||  rr_ptr);
  assign pop     = gnt & {2{!bus.flush}};
  assign any_gnt = |pop;
  assign head_p0 = gnt[1] ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];

  // FIFO storage; entries need no reset because count gates every read
  always_ff @(posedge clk1) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= in_ent[s];
    end
  end

  // FIFO pointers/counts and the round-robin pointer
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      rr_ptr <= 1'b0;
    end else if (bus.flush) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      rr_ptr <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_ONE;
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_ONE;
        case ({push[s], pop[s]})
          2'b10:   cnt[s] <= cnt[s] + CNT_ONE;
          2'b01:   cnt[s] <= cnt[s] - CNT_ONE;
          default: cnt[s] <= cnt[s];
        endcase
      end
      // the source that lost (or was idle) gets priority next time
      if (any_gnt) rr_ptr <= pop[0];
    end
  end

  // ---- stage p1: registered broadcast; fields hold when nothing is granted
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      src_p1 <= 1'b0;
      ent_p1 <= '0;
    end else begin
      vld_p1 <= any_gnt;
      if (any_gnt) begin
        src_p1 <= pop[1];
        ent_p1 <= head_p0;
      end
    end
  end

  assign bus.add_ready = rdy[0];
  assign bus.mul_ready = rdy[1];
  assign bus.cdb_valid = vld_p1;
  assign bus.cdb_src   = src_p1;
  assign {bus.cdb_rob_ind, bus.cdb_rd, bus.cdb_data} = ent_p1;

`ifdef CDB_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // saturating perf counters, cleared by reset only
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      perf_add_cnt      <= '0;
      perf_mul_cnt      <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      perf_add_cnt      <= sat_inc(perf_add_cnt, pop[0]);
      perf_mul_cnt      <= sat_inc(perf_mul_cnt, pop[1]);
      perf_conflict_cnt <= sat_inc(perf_conflict_cnt, &ne);
    end
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Result-return side of the reservation-station protocol.
- Accepts completed results from the add/branch/load-store exec path and the mul/div exec path.
- Buffers each in a small per-source FIFO, round-robin arbitrates, and broadcasts one {rob_ind, rd, data} per cycle on the common data bus.
- RS entries and the ROB snoop the CDB to wake pending operands (clear busy, capture value).

Parameters:
- DATA_W, 16, result data width
- TAG_W, 3, ROB index width (matches rob_ind)
- RD_W, 4, destination register width
- DEPTH, 2, entries per source FIFO (power of 2, >=2)

Ports:
- clk1  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all buffered results (mispredict)
- add_valid  in  1  add-unit result present
- add_ready  out  1  add FIFO can accept (not full)
- add_rob_ind  in  TAG_W  ROB tag of add result
- add_rd  in  RD_W  destination register of add result
- add_data  in  DATA_W  add result value
- mul_valid  in  1  mul-unit result present
- mul_ready  out  1  mul FIFO can accept (not full)
- mul_rob_ind  in  TAG_W  ROB tag of mul result
- mul_rd  in  RD_W  destination register of mul result
- mul_data  in  DATA_W  mul result value
- cdb_valid  out  1  broadcast valid this cycle
- cdb_src  out  1  0 = add source, 1 = mul source
- cdb_rob_ind  out  TAG_W  broadcast tag
- cdb_rd  out  RD_W  broadcast destination
- cdb_data  out  DATA_W  broadcast value

Behaviour:
- Reset (async, active-high): both FIFOs empty, rr_ptr=0 (add priority), cdb_valid=0, cdb_src=0, cdb_rob_ind/cdb_rd/cdb_data=0. add_ready=mul_ready=1 once reset deasserts. Reset mid-burst discards all buffered results.
- Push: on posedge, if x_valid && x_ready, write {rob_ind, rd, data} at wr_ptr and increment. x_valid with !x_ready is ignored; the producer must hold.
- x_ready = !full, from registered count only. A full FIFO popped in the same cycle still reports ready=0 (no same-cycle pass-through).
- Pointers wrap modulo DEPTH. Count is in 0..DEPTH and distinguishes full from empty.
- Arbitration is combinational over FIFO heads each cycle:
  - both non-empty: grant the source selected by rr_ptr;
  - one non-empty: grant it;
  - none: no grant.
- On a grant:
  - pop that FIFO;
  - set rr_ptr = the non-granted source;
  - register head fields to cdb_* with cdb_valid=1 for exactly one cycle.
- With no grant: cdb_valid=0 and cdb_* data fields hold their last value.
- Latency: a result accepted at edge N appears on the CDB after edge N+1 at the earliest. Throughput is 1 broadcast/cycle total.
- Simultaneous push and pop on the same FIFO is legal; count is unchanged.
- Flush (priority over push, pop and grant): at the next edge both FIFOs empty, cdb_valid=0, rr_ptr=0. Inputs presented in the flush cycle are dropped.
- Ordering: per-source FIFO order is preserved; interleaving between sources is round-robin only.
- Integrity: no result is duplicated or lost except by reset/flush.

Optional Feature:
- Macro CDB_PERF_EN.
- Defined:
  - adds outputs perf_add_cnt[15:0], perf_mul_cnt[15:0] (broadcasts per source) and perf_conflict_cnt[15:0] (cycles where both heads were valid);
  - all counters saturate at 16'hFFFF;
  - cleared by reset only, not by flush.
- Undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Single add result: add_valid=1, rob_ind=3, rd=5, data=16'h0042 at edge 1 -> after edge 2 cdb_valid=1, cdb_src=0, cdb_rob_ind=3, cdb_rd=5, cdb_data=16'h0042; after edge 3 cdb_valid=0.
- Contention: add tags 1,2 and mul tags 4,5 pushed together over two cycles -> CDB order 1,4,2,5 (add wins first at rr_ptr=0, then alternates).
- Backpressure: 3 consecutive add pushes with DEPTH=2 and mul saturating the CDB -> add_ready=0 after 2 accepts; 3rd held result is accepted once a slot frees; all 3 broadcast in order, none lost.
- Flush: both FIFOs full, flush=1 for one cycle -> next cycle cdb_valid=0, add_ready=mul_ready=1; no stale tag is ever broadcast.
- Async reset mid-broadcast: assert reset between edges while cdb_valid=1 -> cdb_valid=0 immediately, without waiting for an edge; FIFOs empty after release.
- With CDB_PERF_EN: 3 add and 2 mul broadcasts including 2 conflict cycles -> perf_add_cnt=3, perf_mul_cnt=2, perf_conflict_cnt=2.
